// File: rtl/past_check_ctrl.sv
// Hardware monitor for "a |-> ($past(b, N) == EXPECT)" with run-time N and EXPECT.
// Optional stop-on-first-fail behaviour is selected by PAST_CHECK_STOP_ON_FAIL_EN.
module past_check_ctrl #(
    parameter int MAX_DEPTH = 8,
    parameter int CNT_W     = 16,
    parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               clr,
    input  logic               cfg_load,
    input  logic [DEPTH_W-1:0] cfg_depth,
    input  logic               cfg_expect,
    input  logic               a,
    input  logic               b,
    output logic               pass_pulse,
    output logic               fail_pulse,
    output logic               vac_pulse,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic [CNT_W-1:0]   vac_cnt,
    output logic               warm,
    output logic [1:0]         state_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WARMUP = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);
    localparam logic [DEPTH_W-1:0] ONE_D = DEPTH_W'(1);

`ifdef PAST_CHECK_STOP_ON_FAIL_EN
    localparam logic STOP_EN = 1'b1;
`else
    localparam logic STOP_EN = 1'b0;
`endif

    function automatic logic [DEPTH_W-1:0] clamp_depth(input logic [DEPTH_W-1:0] d);
        logic [DEPTH_W-1:0] r;
        if (d == {DEPTH_W{1'b0}}) begin
            r = ONE_D;
        end else if (d > MAX_D) begin
            r = MAX_D;
        end else begin
            r = d;
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (&c) begin
            r = c;
        end else begin
            r = c + CNT_W'(1);
        end
        return r;
    endfunction

    logic [1:0]           state_r;
    logic [1:0]           state_nx_s;
    logic [MAX_DEPTH-1:0] hist_r;
    logic [DEPTH_W-1:0]   fill_r;
    logic [DEPTH_W-1:0]   fill_inc_s;
    logic [DEPTH_W-1:0]   depth_r;
    logic                 expect_r;
    logic                 running_s;
    logic                 active_s;
    logic                 past_s;
    logic                 past_eff_s;
    logic                 res_pass_s;
    logic                 res_fail_s;
    logic                 res_vac_s;

    assign running_s = (state_r == S_WARMUP) || (state_r == S_CHECK);
    // An edge only shifts and evaluates when running, enabled and not being cleared.
    assign active_s  = running_s && enable && !clr;
    assign state_o   = state_r;

    // Select the sample taken depth_r edges ago without a variable-width index.
    always_comb begin
        past_s = 1'b0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            past_s = past_s | ((depth_r == DEPTH_W'(i + 1)) & hist_r[i]);
        end
    end

    // Evaluation of the current edge and saturating fill increment.
    always_comb begin
        fill_inc_s = (fill_r == MAX_D) ? fill_r : (fill_r + ONE_D);
        past_eff_s = (fill_r >= depth_r) ? past_s : 1'b0;
        res_vac_s  = !a;
        res_pass_s = a && (past_eff_s == expect_r);
        res_fail_s = a && (past_eff_s != expect_r);
    end

    // Next-state logic; clr overrides everything.
    always_comb begin
        state_nx_s = state_r;
        if (clr) begin
            state_nx_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (enable) state_nx_s = S_WARMUP;
                    else        state_nx_s = S_IDLE;
                end
                S_WARMUP: begin
                    if (!enable)                      state_nx_s = S_IDLE;
                    else if (STOP_EN && res_fail_s)   state_nx_s = S_HALT;
                    else if (fill_inc_s == depth_r)   state_nx_s = S_CHECK;
                    else                              state_nx_s = S_WARMUP;
                end
                S_CHECK: begin
                    if (!enable)                      state_nx_s = S_IDLE;
                    else if (STOP_EN && res_fail_s)   state_nx_s = S_HALT;
                    else                              state_nx_s = S_CHECK;
                end
                S_HALT: begin
                    if (STOP_EN) state_nx_s = S_HALT;
                    else         state_nx_s = S_IDLE;
                end
                default: state_nx_s = S_IDLE;
            endcase
        end
    end

    // State register and registered warm-up flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            warm    <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            warm    <= (state_nx_s == S_WARMUP);
        end
    end

    // Configuration latch, only writable while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_r  <= ONE_D;
            expect_r <= 1'b0;
        end else if (!clr && cfg_load && (state_r == S_IDLE)) begin
            depth_r  <= clamp_depth(cfg_depth);
            expect_r <= cfg_expect;
        end else begin
            depth_r  <= depth_r;
            expect_r <= expect_r;
        end
    end

    // b history delay line and fill counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r <= {MAX_DEPTH{1'b0}};
            fill_r <= {DEPTH_W{1'b0}};
        end else if (clr || ((state_r == S_IDLE) && enable)) begin
            hist_r <= {MAX_DEPTH{1'b0}};
            fill_r <= {DEPTH_W{1'b0}};
        end else if (active_s) begin
            hist_r[0] <= b;
            for (int i = 1; i < MAX_DEPTH; i++) begin
                hist_r[i] <= hist_r[i-1];
            end
            fill_r <= fill_inc_s;
        end else if (running_s) begin
            fill_r <= {DEPTH_W{1'b0}};
        end else begin
            fill_r <= fill_r;
        end
    end

    // Result strobes and saturating statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_pulse <= 1'b0;
            fail_pulse <= 1'b0;
            vac_pulse  <= 1'b0;
            pass_cnt   <= {CNT_W{1'b0}};
            fail_cnt   <= {CNT_W{1'b0}};
            vac_cnt    <= {CNT_W{1'b0}};
        end else if (clr) begin
            pass_pulse <= 1'b0;
            fail_pulse <= 1'b0;
            vac_pulse  <= 1'b0;
            pass_cnt   <= {CNT_W{1'b0}};
            fail_cnt   <= {CNT_W{1'b0}};
            vac_cnt    <= {CNT_W{1'b0}};
        end else if (active_s) begin
            pass_pulse <= res_pass_s;
            fail_pulse <= res_fail_s;
            vac_pulse  <= res_vac_s;
            if (res_pass_s) pass_cnt <= sat_inc(pass_cnt);
            else            pass_cnt <= pass_cnt;
            if (res_fail_s) fail_cnt <= sat_inc(fail_cnt);
            else            fail_cnt <= fail_cnt;
            if (res_vac_s)  vac_cnt  <= sat_inc(vac_cnt);
            else            vac_cnt  <= vac_cnt;
        end else begin
            pass_pulse <= 1'b0;
            fail_pulse <= 1'b0;
            vac_pulse  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_past_check_ctrl.sv
// Directed bench for past_check_ctrl; expected values are hand-derived per step.
module tb_past_check_ctrl;

    localparam int MAX_DEPTH = 8;
    localparam int CNT_W     = 4;
    localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic               clr;
    logic               cfg_load;
    logic [DEPTH_W-1:0] cfg_depth;
    logic               cfg_expect;
    logic               a;
    logic               b;
    logic               pass_pulse;
    logic               fail_pulse;
    logic               vac_pulse;
    logic [CNT_W-1:0]   pass_cnt;
    logic [CNT_W-1:0]   fail_cnt;
    logic [CNT_W-1:0]   vac_cnt;
    logic               warm;
    logic [1:0]         state_o;

    int total = 0;
    int bad   = 0;

    past_check_ctrl #(.MAX_DEPTH(MAX_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr),
        .cfg_load(cfg_load), .cfg_depth(cfg_depth), .cfg_expect(cfg_expect),
        .a(a), .b(b),
        .pass_pulse(pass_pulse), .fail_pulse(fail_pulse), .vac_pulse(vac_pulse),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .vac_cnt(vac_cnt),
        .warm(warm), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] st, input logic wm,
                           input logic p, input logic f, input logic v);
        chk({tag, "_state"}, 32'(state_o), 32'(st));
        chk({tag, "_warm"},  32'(warm),    32'(wm));
        chk({tag, "_pass"},  32'(pass_pulse), 32'(p));
        chk({tag, "_fail"},  32'(fail_pulse), 32'(f));
        chk({tag, "_vac"},   32'(vac_pulse),  32'(v));
    endtask

    task automatic chk_cnt(input string tag, input int p, input int f, input int v);
        chk({tag, "_pcnt"}, 32'(pass_cnt), 32'(p));
        chk({tag, "_fcnt"}, 32'(fail_cnt), 32'(f));
        chk({tag, "_vcnt"}, 32'(vac_cnt),  32'(v));
    endtask

    task automatic step(input logic en, input logic ai, input logic bi);
        enable = en;
        a      = ai;
        b      = bi;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DEPTH_W-1:0] d, input logic e);
        cfg_load   = 1'b1;
        cfg_depth  = d;
        cfg_expect = e;
        step(1'b0, 1'b0, 1'b0);
        cfg_load   = 1'b0;
    endtask

    task automatic async_reset_check(input string tag);
        rst_n = 1'b0;
        #2;
        chk_out(tag, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt(tag, 0, 0, 0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; clr = 1'b0; cfg_load = 1'b0;
        cfg_depth = {DEPTH_W{1'b0}}; cfg_expect = 1'b0; a = 1'b0; b = 1'b0;
        #1;
        chk_out("rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("rst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifndef PAST_CHECK_STOP_ON_FAIL_EN
        // depth 2, expect 0: vac, pass (history not yet valid), fail, vac, fail
        load(4'd2, 1'b0);
        step(1'b1, 1'b0, 1'b0); chk_out("entry", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1); chk_out("e1",    2'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0); chk_out("e2",    2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1); chk_out("e3",    2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0); chk_out("e4",    2'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1); chk_out("e5",    2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_cnt("basic", 1, 2, 2);
        async_reset_check("arst");
`else
        // same stream, the first fail freezes the monitor in HALT
        load(4'd2, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1); chk_out("h_fail", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_cnt("h_fail", 1, 1, 1);
        step(1'b1, 1'b1, 1'b0); chk_out("h_frz1", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1); chk_out("h_frz2", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("h_frz2", 1, 1, 1);
        clr = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        chk_out("h_clr", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("h_clr", 0, 0, 0);
        step(1'b1, 1'b0, 1'b0); chk_out("h_resume", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0); chk_out("h_res_e1", 2'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_cnt("h_res_e1", 0, 0, 1);
        async_reset_check("arst");
`endif

        // cfg_depth 0 clamps to 1: warm drops after the first active edge
        load(4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0); chk_out("d0_entry", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0); chk_out("d0_e1",    2'd2, 1'b0, 1'b0, 1'b0, 1'b1);

        // cfg_load while checking is ignored
        cfg_load = 1'b1; cfg_depth = 4'd5; cfg_expect = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        cfg_load = 1'b0;
        chk("lock_state", 32'(state_o), 32'd2);
        step(1'b0, 1'b0, 1'b0); chk_out("lock_off", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0); chk("lock_entry", 32'(state_o), 32'd1);
        step(1'b1, 1'b0, 1'b0); chk_out("lock_e1", 2'd2, 1'b0, 1'b0, 1'b0, 1'b1);

        // cfg_depth 15 clamps to 8: warm-up lasts eight active edges
        step(1'b0, 1'b0, 1'b0);
        load(4'd15, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
        chk_out("d15_e7", 2'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk_out("d15_e8", 2'd2, 1'b0, 1'b0, 1'b0, 1'b1);

        // pass counter saturates at 15 without wrapping
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0);
        chk("sat15", 32'(pass_cnt), 32'd15);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        chk_out("sat20", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("sat20_pcnt", 32'(pass_cnt), 32'd15);
        chk("sat20_fcnt", 32'(fail_cnt), 32'd0);

        // clr beats enable and cfg_load in CHECK
        clr = 1'b1; cfg_load = 1'b1; cfg_depth = 4'd3; cfg_expect = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        clr = 1'b0; cfg_load = 1'b0;
        chk_out("clr", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("clr", 0, 0, 0);

        // depth 8 / expect 0 retained: b=1 on first edge fails at the ninth
        step(1'b1, 1'b0, 1'b0); chk("keep_entry", 32'(state_o), 32'd1);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
        chk("keep_e7", 32'(state_o), 32'd1);
        step(1'b1, 1'b0, 1'b0); chk("keep_e8", 32'(state_o), 32'd2);
        step(1'b1, 1'b1, 1'b0);
`ifdef PAST_CHECK_STOP_ON_FAIL_EN
        chk_out("full_fail", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
`else
        chk_out("full_fail", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
        chk("full_fcnt", 32'(fail_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
